// File: rtl/vita49_trig_sched.sv
// vita49_trig_sched: walks vita49_trig_logic through a FIFO of {on, off} timestamp windows.
// Latency: a push lands in the FIFO two edges after its rising edge; every output is registered.
// Backpressure: none; pushes into a full FIFO are dropped and flagged as overflow.
module vita49_trig_sched #(
  parameter int C_DEPTH_LOG2 = 3
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic [31:0] sched_ctrl,
  input  logic [31:0] win_tsi_on,
  input  logic [31:0] win_tsf_on_hi,
  input  logic [31:0] win_tsf_on_lo,
  input  logic [31:0] win_tsi_off,
  input  logic [31:0] win_tsf_off_hi,
  input  logic [31:0] win_tsf_off_lo,
  input  logic [31:0] tsi,
  input  logic [63:0] tsf,
  input  logic        trig,
  output logic [31:0] trig_ctrl,
  output logic [31:0] trig_tsi_up,
  output logic [31:0] trig_tsf_hi_up,
  output logic [31:0] trig_tsf_lo_up,
  output logic [31:0] sched_status,
  output logic        win_done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_LOAD_ON  = 3'd2,
    ST_LOAD_OFF = 3'd3,
    ST_WAIT_ON  = 3'd4,
    ST_WAIT_OFF = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // A window is a pair of 96-bit {seconds, fraction} timestamps.
  typedef struct packed {
    logic [95:0] on_t;
    logic [95:0] off_t;
  } win_t;

  localparam int DEPTH  = 1 << C_DEPTH_LOG2;
  localparam int FILL_W = C_DEPTH_LOG2 + 1;

  logic enable, flush, push_bit;
  assign enable   = sched_ctrl[0];
  assign flush    = sched_ctrl[1];
  assign push_bit = sched_ctrl[2];

  logic unused_ctrl;
  assign unused_ctrl = ^sched_ctrl[31:4];

  // Timing-unit bus, trig and control sampling.
  logic [31:0] tsi_q;
  logic [63:0] tsf_q;
  logic        trig_q;
  logic        pt_q;
  logic        push_d;
  logic        push_pend;
  win_t        cap;

  // Window FIFO.
  win_t                    mem [DEPTH];
  logic [C_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FILL_W-1:0]       fill;
  logic                    empty, full;
  logic                    valid_win, fifo_wr, do_push, pop, do_pop;
  win_t                    head;

  // Status and FSM state.
  logic        ovf_q, inv_q;
  logic [15:0] late_cnt;
  state_t      state, state_nx;
  logic        late_q, late_nx;
  logic        nopop_q, nopop_nx;
  logic [2:0]  guard_q, guard_nx;
  logic [3:0]  ctrl_q, ctrl_nx;
  logic        done_nx;
  logic        off_reached;

  assign empty     = (fill == '0);
  assign full      = (fill == FILL_W'(DEPTH));
  assign head      = mem[rd_ptr];
  assign valid_win = (cap.off_t > cap.on_t);
  // Flush wins over a pending push; invalid windows never reach the FIFO.
  assign fifo_wr   = push_pend & ~flush & valid_win;
  // Flushed windows (nopop) are already gone, so DONE only pops on a normal retire.
  assign pop       = (state == ST_DONE) & ~nopop_q & ~flush;
  assign do_pop    = pop & ~empty;
  assign do_push   = fifo_wr & (~full | do_pop);

  assign off_reached = ({tsi_q, tsf_q} >= head.off_t);

  // Register the time bus, trig and passthrough request once.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      tsi_q  <= '0;
      tsf_q  <= '0;
      trig_q <= 1'b0;
      pt_q   <= 1'b0;
    end else begin
      tsi_q  <= tsi;
      tsf_q  <= tsf;
      trig_q <= trig;
      pt_q   <= sched_ctrl[3];
    end
  end

  // Detect the push rising edge and capture the window for the next edge.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      push_d    <= 1'b0;
      push_pend <= 1'b0;
      cap       <= '0;
    end else begin
      push_d    <= push_bit;
      push_pend <= push_bit & ~push_d & ~flush;
      if (push_bit && !push_d) begin
        cap <= {win_tsi_on, win_tsf_on_hi, win_tsf_on_lo,
                win_tsi_off, win_tsf_off_hi, win_tsf_off_lo};
      end
    end
  end

  // FIFO storage write.
  always_ff @(posedge AXIS_ACLK) begin
    if (do_push) begin
      mem[wr_ptr] <= cap;
    end
  end

  // FIFO pointers and fill; pointers wrap naturally.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Sticky invalid/overflow flags.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET || flush) begin
      inv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (push_pend && !valid_win) inv_q <= 1'b1;
      if (fifo_wr && !do_push)     ovf_q <= 1'b1;
    end
  end

  // Saturating count of windows retired late.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET || flush) begin
      late_cnt <= '0;
    end else if (state == ST_DONE && late_q && late_cnt != 16'hFFFF) begin
      late_cnt <= late_cnt + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state   <= ST_IDLE;
      late_q  <= 1'b0;
      nopop_q <= 1'b0;
      guard_q <= '0;
    end else begin
      state   <= state_nx;
      late_q  <= late_nx;
      nopop_q <= nopop_nx;
      guard_q <= guard_nx;
    end
  end

  // Next state: flush, then enable drop, then the normal window sequence.
  always_comb begin
    state_nx = state;
    late_nx  = late_q;
    nopop_nx = nopop_q;
    guard_nx = 3'd0;
    if (flush) begin
      if (state != ST_IDLE && state != ST_DONE) begin
        state_nx = ST_DONE;
        late_nx  = 1'b0;
        nopop_nx = 1'b1;
      end else begin
        state_nx = ST_IDLE;
      end
    end else if (!enable && state != ST_IDLE && state != ST_DONE) begin
      state_nx = ST_DONE;
      late_nx  = 1'b0;
      nopop_nx = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && !empty) begin
            state_nx = ST_CHECK;
            late_nx  = 1'b0;
            nopop_nx = 1'b0;
          end
        end
        ST_CHECK: begin
          if (off_reached) begin
            state_nx = ST_DONE;
            late_nx  = 1'b1;
          end else begin
            state_nx = ST_LOAD_ON;
          end
        end
        ST_LOAD_ON:  state_nx = ST_LOAD_OFF;
        ST_LOAD_OFF: state_nx = ST_WAIT_ON;
        ST_WAIT_ON: begin
          // Missed-window guard: off-time passed and trig never rose.
          if (trig) begin
            state_nx = ST_WAIT_OFF;
          end else if (off_reached) begin
            if (guard_q == 3'd4) begin
              state_nx = ST_DONE;
              late_nx  = 1'b1;
            end else begin
              guard_nx = guard_q + 3'd1;
            end
          end
        end
        ST_WAIT_OFF: begin
          if (!trig) state_nx = ST_DONE;
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
    ctrl_nx = {state_nx == ST_LOAD_OFF, state_nx == ST_LOAD_ON, state_nx == ST_DONE,
               (state_nx == ST_WAIT_ON) || (state_nx == ST_WAIT_OFF)};
    done_nx = (state_nx == ST_DONE) && !nopop_nx;
  end

  // Registered trigger-unit controls; operands move on the same edge as their set bit.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      ctrl_q         <= '0;
      win_done       <= 1'b0;
      trig_tsi_up    <= '0;
      trig_tsf_hi_up <= '0;
      trig_tsf_lo_up <= '0;
    end else begin
      ctrl_q   <= ctrl_nx;
      win_done <= done_nx;
      case (state_nx)
        ST_LOAD_ON:  {trig_tsi_up, trig_tsf_hi_up, trig_tsf_lo_up} <= head.on_t;
        ST_LOAD_OFF: {trig_tsi_up, trig_tsf_hi_up, trig_tsf_lo_up} <= head.off_t;
        ST_DONE:     {trig_tsi_up, trig_tsf_hi_up, trig_tsf_lo_up} <= '0;
        default: ;
      endcase
    end
  end

  assign trig_ctrl    = {27'd0, pt_q, ctrl_q};
  assign sched_status = {late_cnt, trig_q, state, inv_q, ovf_q, full, empty, 8'(fill)};

endmodule

// File: tb/tb_vita49_trig_sched.sv
// tb_vita49_trig_sched: directed table plus hand-written sequences for the window scheduler.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: none; every wait on the DUT is bounded.
module tb_vita49_trig_sched;

  logic        clk;
  logic        rst;
  logic        en_b, flush_b, push_b, pt_b;
  logic [31:0] sched_ctrl;
  logic [31:0] win_tsi_on, win_tsf_on_hi, win_tsf_on_lo;
  logic [31:0] win_tsi_off, win_tsf_off_hi, win_tsf_off_lo;
  logic [31:0] tsi;
  logic [63:0] tsf;
  logic        trig;
  logic [31:0] trig_ctrl, trig_tsi_up, trig_tsf_hi_up, trig_tsf_lo_up, sched_status;
  logic        win_done;

  assign sched_ctrl = {28'd0, pt_b, push_b, flush_b, en_b};

  vita49_trig_sched #(.C_DEPTH_LOG2(3)) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESET    (rst),
    .sched_ctrl     (sched_ctrl),
    .win_tsi_on     (win_tsi_on),
    .win_tsf_on_hi  (win_tsf_on_hi),
    .win_tsf_on_lo  (win_tsf_on_lo),
    .win_tsi_off    (win_tsi_off),
    .win_tsf_off_hi (win_tsf_off_hi),
    .win_tsf_off_lo (win_tsf_off_lo),
    .tsi            (tsi),
    .tsf            (tsf),
    .trig           (trig),
    .trig_ctrl      (trig_ctrl),
    .trig_tsi_up    (trig_tsi_up),
    .trig_tsf_hi_up (trig_tsf_hi_up),
    .trig_tsf_lo_up (trig_tsf_lo_up),
    .sched_status   (sched_status),
    .win_done       (win_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rst_pulses = 0;
  int done_pulses = 0;

  // Count reset pulses and retirements seen by the trigger unit.
  always @(negedge clk) begin
    if (trig_ctrl[1]) rst_pulses++;
    if (win_done)     done_pulses++;
  end

  logic [7:0]  fill_o;
  logic [2:0]  st_o;
  logic [15:0] late_o;
  assign fill_o = sched_status[7:0];
  assign st_o   = sched_status[14:12];
  assign late_o = sched_status[31:16];

  typedef struct {
    bit          is_flush;
    logic [31:0] on_i;
    logic [63:0] on_f;
    logic [31:0] off_i;
    logic [63:0] off_f;
    int          fill;
    bit          full;
    bit          ovf;
    bit          inv;
    int          late;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input bit fl, input logic [31:0] oi, input logic [63:0] of,
                              input logic [31:0] fi, input logic [63:0] ff, input int fill,
                              input bit full, input bit ovf, input bit inv, input int late);
    vec_t v;
    v.is_flush = fl;
    v.on_i = oi;  v.on_f = of;  v.off_i = fi;  v.off_f = ff;
    v.fill = fill; v.full = full; v.ovf = ovf; v.inv = inv; v.late = late;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_win(input logic [31:0] oi, input logic [63:0] of,
                          input logic [31:0] fi, input logic [63:0] ff);
    win_tsi_on     = oi;
    win_tsf_on_hi  = of[63:32];
    win_tsf_on_lo  = of[31:0];
    win_tsi_off    = fi;
    win_tsf_off_hi = ff[63:32];
    win_tsf_off_lo = ff[31:0];
    push_b = 1'b1;
    tick(1);
    push_b = 1'b0;
    tick(1);
  endtask

  task automatic wait_load_on(input string name);
    int n;
    n = 0;
    while (!trig_ctrl[2] && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (!trig_ctrl[2]) begin
      failures++;
      $display("FAIL %s: set_on not seen within 20 cycles", name);
    end
  endtask

  task automatic run_window(input logic [31:0] on_i, input logic [31:0] off_i);
    int r0, d0;
    r0 = rst_pulses;
    d0 = done_pulses;
    wait_load_on($sformatf("win%0d load_on", on_i));
    chk($sformatf("win%0d on up", on_i), 64'(trig_tsi_up), 64'(on_i));
    tick(1);
    chk($sformatf("win%0d set_off", on_i), 64'(trig_ctrl), 64'h8);
    chk($sformatf("win%0d off up", on_i), 64'(trig_tsi_up), 64'(off_i));
    tick(1);
    chk($sformatf("win%0d wait_on", on_i), 64'(st_o), 64'd4);
    trig = 1'b1;
    tick(1);
    chk($sformatf("win%0d wait_off", on_i), 64'(st_o), 64'd5);
    trig = 1'b0;
    tick(1);
    chk($sformatf("win%0d done ctrl", on_i), 64'(trig_ctrl), 64'h2);
    chk($sformatf("win%0d done pulse", on_i), 64'(win_done), 64'd1);
    tick(1);
    chk($sformatf("win%0d reset pulses", on_i), 64'(rst_pulses - r0), 64'd1);
    chk($sformatf("win%0d done pulses", on_i), 64'(done_pulses - d0), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1;
    en_b = 1'b0; flush_b = 1'b0; push_b = 1'b0; pt_b = 1'b0;
    win_tsi_on = '0; win_tsf_on_hi = '0; win_tsf_on_lo = '0;
    win_tsi_off = '0; win_tsf_off_hi = '0; win_tsf_off_lo = '0;
    tsi = '0; tsf = '0; trig = 1'b0;

    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 32'(100 + i), 64'd0, 32'(101 + i), 64'd0, i + 1, i == 7, 0, 0, 1));
    vq.push_back(mk(0, 32'd200, 64'd0, 32'd201, 64'd0, 8, 1, 1, 0, 1));
    vq.push_back(mk(0, 32'd20, 64'd5, 32'd20, 64'd5, 8, 1, 1, 1, 1));
    vq.push_back(mk(1, 32'd0, 64'd0, 32'd0, 64'd0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 32'd41, 64'd9, 32'd41, 64'd8, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 32'd50, 64'd0, 32'd49, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 32'd0, 64'd0, 32'd0, 64'd0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 32'd40, 64'd5, 32'd40, 64'd6, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'd0, 64'd0, 32'd0, 64'd0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 32'd30, 64'd0, 32'd31, 64'd0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 32'd32, 64'd0, 32'd33, 64'd0, 2, 0, 0, 0, 0));
    vq.push_back(mk(0, 32'd34, 64'd0, 32'd35, 64'd0, 3, 0, 0, 0, 0));

    // Reset values.
    tick(3);
    chk("reset trig_ctrl", 64'(trig_ctrl), 64'h0);
    chk("reset tsi_up", 64'(trig_tsi_up), 64'h0);
    chk("reset win_done", 64'(win_done), 64'h0);
    chk("reset status", 64'(sched_status), 64'h100);
    rst = 1'b0;
    tick(1);

    // Single window sequenced end to end.
    tsi = 32'd9;
    push_win(32'd10, 64'd0, 32'd12, 64'd0);
    chk("basic fill after push", 64'(fill_o), 64'd1);
    en_b = 1'b1;
    tick(1);
    chk("basic check state", 64'(st_o), 64'd1);
    tick(1);
    chk("basic set_on", 64'(trig_ctrl), 64'h4);
    chk("basic on tsi", 64'(trig_tsi_up), 64'd10);
    chk("basic on tsf", {trig_tsf_hi_up, trig_tsf_lo_up}, 64'd0);
    tick(1);
    chk("basic set_off", 64'(trig_ctrl), 64'h8);
    chk("basic off tsi", 64'(trig_tsi_up), 64'd12);
    tick(1);
    chk("basic enable", 64'(trig_ctrl), 64'h1);
    chk("basic wait_on", 64'(st_o), 64'd4);
    tsi = 32'd10;
    tick(3);
    trig = 1'b1;
    tick(1);
    chk("basic wait_off", 64'(st_o), 64'd5);
    chk("basic status trig", 64'(sched_status[15]), 64'd1);
    tsi = 32'd12;
    tick(2);
    chk("basic hold wait_off", 64'(st_o), 64'd5);
    trig = 1'b0;
    tick(1);
    chk("basic done state", 64'(st_o), 64'd6);
    chk("basic done ctrl", 64'(trig_ctrl), 64'h2);
    chk("basic win_done", 64'(win_done), 64'd1);
    chk("basic done up zero", 64'(trig_tsi_up), 64'd0);
    chk("basic fill in done", 64'(fill_o), 64'd1);
    tick(1);
    chk("basic idle", 64'(st_o), 64'd0);
    chk("basic ctrl idle", 64'(trig_ctrl), 64'h0);
    chk("basic win_done low", 64'(win_done), 64'd0);
    chk("basic fill end", 64'(fill_o), 64'd0);
    chk("basic empty", 64'(sched_status[8]), 64'd1);
    chk("basic late", 64'(late_o), 64'd0);

    // Window already past its off-time: late, no set_on.
    tsi = 32'd8;
    push_win(32'd4, 64'd0, 32'd5, 64'd0);
    tick(1);
    chk("late check state", 64'(st_o), 64'd1);
    chk("late check ctrl", 64'(trig_ctrl), 64'h0);
    tick(1);
    chk("late done state", 64'(st_o), 64'd6);
    chk("late done ctrl", 64'(trig_ctrl), 64'h2);
    chk("late win_done", 64'(win_done), 64'd1);
    tick(1);
    chk("late count", 64'(late_o), 64'd1);
    chk("late fill", 64'(fill_o), 64'd0);
    en_b = 1'b0;
    tick(1);

    // Push/flush table: fill, full, overflow, invalid, late count.
    for (int k = 0; k < vq.size(); k++) begin
      if (vq[k].is_flush) begin
        flush_b = 1'b1;
        tick(1);
        flush_b = 1'b0;
        tick(1);
      end else begin
        push_win(vq[k].on_i, vq[k].on_f, vq[k].off_i, vq[k].off_f);
      end
      chk($sformatf("vec%0d fill", k), 64'(fill_o), 64'(vq[k].fill));
      chk($sformatf("vec%0d full", k), 64'(sched_status[9]), 64'(vq[k].full));
      chk($sformatf("vec%0d overflow", k), 64'(sched_status[10]), 64'(vq[k].ovf));
      chk($sformatf("vec%0d invalid", k), 64'(sched_status[11]), 64'(vq[k].inv));
      chk($sformatf("vec%0d late", k), 64'(late_o), 64'(vq[k].late));
    end

    // Three queued windows back to back, in order.
    tsi = 32'd29;
    tick(1);
    en_b = 1'b1;
    run_window(32'd30, 32'd31);
    run_window(32'd32, 32'd33);
    run_window(32'd34, 32'd35);
    chk("b2b empty", 64'(sched_status[8]), 64'd1);
    chk("b2b idle", 64'(st_o), 64'd0);

    // Enable dropped during WAIT_OFF.
    tsi = 32'd59;
    push_win(32'd60, 64'd0, 32'd61, 64'd0);
    wait_load_on("endrop load_on");
    tick(2);
    trig = 1'b1;
    tick(1);
    chk("endrop wait_off", 64'(st_o), 64'd5);
    en_b = 1'b0;
    tick(1);
    chk("endrop done state", 64'(st_o), 64'd6);
    chk("endrop done ctrl", 64'(trig_ctrl), 64'h2);
    chk("endrop win_done", 64'(win_done), 64'd1);
    trig = 1'b0;
    tick(1);
    chk("endrop idle", 64'(st_o), 64'd0);
    chk("endrop fill", 64'(fill_o), 64'd0);
    chk("endrop late", 64'(late_o), 64'd0);

    // Missed-window guard: off-time passes with trig low.
    en_b = 1'b1;
    tsi = 32'd69;
    push_win(32'd70, 64'd0, 32'd71, 64'd0);
    wait_load_on("guard load_on");
    tick(2);
    chk("guard wait_on", 64'(st_o), 64'd4);
    tsi = 32'd71;
    tick(5);
    chk("guard still waiting", 64'(st_o), 64'd4);
    tick(1);
    chk("guard done state", 64'(st_o), 64'd6);
    chk("guard win_done", 64'(win_done), 64'd1);
    tick(1);
    chk("guard late", 64'(late_o), 64'd1);
    chk("guard idle", 64'(st_o), 64'd0);

    // Flush during an active window.
    tsi = 32'd89;
    push_win(32'd90, 64'd0, 32'd91, 64'd0);
    wait_load_on("flush load_on");
    tick(2);
    d0 = done_pulses;
    flush_b = 1'b1;
    tick(1);
    chk("flush done state", 64'(st_o), 64'd6);
    chk("flush reset pulse", 64'(trig_ctrl), 64'h2);
    chk("flush no win_done", 64'(win_done), 64'd0);
    chk("flush fill", 64'(fill_o), 64'd0);
    flush_b = 1'b0;
    tick(1);
    chk("flush idle", 64'(st_o), 64'd0);
    chk("flush late cleared", 64'(late_o), 64'd0);
    chk("flush done count", 64'(done_pulses - d0), 64'd0);

    // Passthrough and reset in the middle of WAIT_ON.
    tsi = 32'd79;
    pt_b = 1'b1;
    push_win(32'd80, 64'd0, 32'd81, 64'd0);
    wait_load_on("rst load_on");
    tick(2);
    chk("rst wait_on passthrough", 64'(trig_ctrl), 64'h11);
    rst = 1'b1;
    tick(1);
    chk("rst trig_ctrl", 64'(trig_ctrl), 64'h0);
    chk("rst tsi_up", 64'(trig_tsi_up), 64'h0);
    chk("rst win_done", 64'(win_done), 64'h0);
    chk("rst status", 64'(sched_status), 64'h100);
    rst = 1'b0;
    en_b = 1'b0;
    pt_b = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vita49_trig_sched.md
Name: vita49_trig_sched

Overview:
Window scheduler that sequences vita49_trig_logic through a queue of processor-programmed {on, off} timestamp windows.
- Holds windows in a small FIFO.
- For each window, drives the trigger unit's ctrl word and *_trig_up operands: load on-time, load off-time, enable, wait for trig to rise and fall, reset unit, then pop.
- Discards windows whose off-time has already passed and counts them as late.
- Sits between the processor register bank and vita49_trig_logic; shares the tsi/tsf timing-unit bus.

Parameters:
C_DEPTH_LOG2, 3, log2 of window FIFO depth (legal 1..7; depth 8 by default)

Ports:
AXIS_ACLK  in  1  clock
AXIS_ARESET  in  1  synchronous active-high reset
sched_ctrl  in  32  [0] enable, [1] flush, [2] push (rising-edge detected), [3] passthrough request, rest ignored
win_tsi_on  in  32  window on-time, integer seconds
win_tsf_on_hi  in  32  on-time fractional, upper 32 bits
win_tsf_on_lo  in  32  on-time fractional, lower 32 bits
win_tsi_off  in  32  window off-time, integer seconds
win_tsf_off_hi  in  32  off-time fractional, upper 32 bits
win_tsf_off_lo  in  32  off-time fractional, lower 32 bits
tsi  in  32  current integer time from timing unit
tsf  in  64  current fractional time from timing unit
trig  in  1  trig output of vita49_trig_logic
trig_ctrl  out  32  ctrl word to vita49_trig_logic: [0] en, [1] reset, [2] set_on, [3] set_off, [4] passthrough, rest 0
trig_tsi_up  out  32  tsi_trig_up operand
trig_tsf_hi_up  out  32  tsf_hi_trig_up operand
trig_tsf_lo_up  out  32  tsf_lo_trig_up operand
sched_status  out  32  [7:0] fill, [8] empty, [9] full, [10] overflow, [11] invalid, [14:12] state, [15] trig, [31:16] late count
win_done  out  1  one-cycle pulse per retired window, including late and aborted windows

Behaviour:
- Reset values:
  - All outputs are registered and reset to 0, except sched_status[8] (empty) = 1.
  - FIFO is empty, sticky bits and late count are 0, state is IDLE.
- Timestamp handling:
  - tsi/tsf are registered once internally.
  - All time comparisons are 96-bit unsigned on {tsi, tsf}.
  - A time t is reached when {tsi_reg, tsf_reg} >= t.
- Push:
  - A rising edge of sched_ctrl[2] samples all six win_* inputs. The entry is written on the following edge, and fill increments in the same cycle.
  - If off <= on, the window is rejected and invalid is set (sticky).
  - If the FIFO is full, the window is dropped and overflow is set (sticky).
  - A push and a pop in the same cycle leave fill unchanged.
- FSM states and encoding: IDLE=0, CHECK=1, LOAD_ON=2, LOAD_OFF=3, WAIT_ON=4, WAIT_OFF=5, DONE=6.
- Transitions:
  - IDLE -> CHECK when enable=1 and the FIFO is not empty.
  - CHECK: if head off-time is reached -> DONE with late flag set; otherwise -> LOAD_ON.
  - LOAD_ON, one cycle: trig_ctrl[2]=1; *_up = head on-time. -> LOAD_OFF.
  - LOAD_OFF, one cycle: trig_ctrl[3]=1; *_up = head off-time. -> WAIT_ON.
  - WAIT_ON: trig_ctrl[0]=1.
    - trig=1 -> WAIT_OFF.
    - Off-time reached locally and trig still 0 for 4 further consecutive cycles -> DONE with late flag set. This is the missed-window guard.
  - WAIT_OFF: trig_ctrl[0]=1. trig=0 -> DONE.
  - DONE, one cycle: trig_ctrl[1]=1; *_up = 0; pop head; win_done=1; late count increments if the late flag is set (saturates at 0xFFFF). -> IDLE.
- Operand timing: *_up values are registered and change on the same edge as their set bit. set_on, set_off and reset are never asserted together.
- Passthrough: trig_ctrl[4] = sched_ctrl[3], registered with 1-cycle latency, in every state. The FSM continues normally.
- Enable deassert: in any state other than IDLE/DONE, the FSM goes to DONE on the next edge. The head entry is discarded, win_done pulses, and the late count does not increment.
- Flush (sched_ctrl[1] level):
  - FIFO pointers, fill, overflow, invalid and late count clear.
  - FSM goes to DONE if not IDLE, with a reset pulse but no pop and no win_done.
  - Flush has priority over push in the same cycle.
- Reset mid-window: AXIS_ARESET returns everything to reset values at the next edge. The trigger unit is reset by its own reset.
- Wrap-around:
  - FIFO pointers are C_DEPTH_LOG2 bits and wrap naturally.
  - fill is C_DEPTH_LOG2+1 bits, zero-extended into [7:0].

Test Plan:
- Push one window on={10,0}, off={12,0}; time starts at {9,0}; enable -> LOAD_ON/LOAD_OFF pulse with *_up = 10/0/0 then 12/0/0; trig rises ~3 cycles after {10,0} and falls after {12,0}; DONE reset pulse; win_done=1; fill 1->0.
- Push window off={5,0} with time at {8,0} -> CHECK goes straight to DONE, no set_on pulse, late count=1, win_done=1.
- Push 9 windows with C_DEPTH_LOG2=3 and enable=0 -> fill=8, full=1, overflow=1; the 9th window is never issued.
- Push window on={20,5}, off={20,5} -> rejected, invalid=1, fill unchanged; flush clears invalid.
- Enable 3 queued windows back-to-back -> windows issue strictly in order; each produces exactly one reset pulse and one win_done; status ends empty=1, state=IDLE.
- Deassert enable during WAIT_OFF -> DONE next cycle, trig_ctrl[1] pulse, entry dropped, late count unchanged; assert AXIS_ARESET mid-WAIT_ON -> all outputs 0 next cycle.
